// File: rtl/cipher_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// cipher_frame_ctrl_if
// Byte-stream handshake bundle for cipher_frame_ctrl.
//   in_valid / in_ready / in_data / in_last     : ciphertext ingress
//   out_valid / out_ready / out_data / out_last : plaintext egress
// slave  : the controller side (accepts ingress, produces egress)
// master : the producer/consumer side
// ---------------------------------------------------------------------------
interface cipher_frame_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/cipher_frame_ctrl.sv
// ---------------------------------------------------------------------------
// cipher_frame_ctrl
// Frame controller for a repeating-key XOR decryptor. Buffers one frame of up
// to MSG_LEN ciphertext bytes, then drains it as buf[i] ^ key[i mod SEC_LEN].
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   key_we/idx/data     key byte write port (idx >= SEC_LEN ignored)
//   io (slave)          ingress/egress valid-ready byte streams
//   busy                state != IDLE
//   frame_len           length of the current/last drained frame
//   key_err             (CIPHER_KEY_LOCK_EN only) one-cycle pulse when a key
//                       write arrives outside IDLE and is dropped
//
// Build option: define CIPHER_KEY_LOCK_EN to freeze the key while a frame is
// in flight.
// ---------------------------------------------------------------------------
module cipher_frame_ctrl #(
   parameter  int MSG_LEN = 20,
   parameter  int SEC_LEN = 3,
   localparam int KW      = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1,
   localparam int FW      = $clog2(MSG_LEN + 1),
   localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_we,
   input  logic [KW-1:0]       key_idx,
   input  logic [7:0]          key_data,
   cipher_frame_ctrl_if.slave  io,
   output logic                busy,
   output logic [FW-1:0]       frame_len
`ifdef CIPHER_KEY_LOCK_EN
   ,
   output logic                key_err
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t        state;
   logic [7:0]    mem   [MSG_LEN];
   logic [7:0]    key_q [SEC_LEN];
   logic [AW-1:0] wr;
   logic [AW-1:0] rd;
   logic [KW-1:0] kidx;

   logic accept;
   logic frame_end;
   logic key_ok;
   logic drain_fire;
   logic drain_end;

   assign accept     = io.in_valid & io.in_ready;
   // In IDLE wr is 0, so the same test also covers the MSG_LEN==1 case.
   assign frame_end  = io.in_last | (wr == AW'(MSG_LEN - 1));
   assign key_ok     = key_we & (int'(key_idx) < SEC_LEN);
   assign drain_fire = io.out_valid & io.out_ready;
   assign drain_end  = drain_fire & io.out_last;

   // Egress is read straight from the registers so a stalled byte holds.
   assign io.out_data = mem[rd] ^ key_q[kidx];
   assign io.out_last = io.out_valid & (FW'(rd) == frame_len - FW'(1));

   // Frame buffer carries no reset; contents are only read after being filled.
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr] <= io.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wr           <= '0;
         rd           <= '0;
         kidx         <= '0;
         frame_len    <= '0;
         io.in_ready  <= 1'b1;
         io.out_valid <= 1'b0;
         busy         <= 1'b0;
         for (int i = 0; i < SEC_LEN; i++)
            key_q[i] <= '0;
`ifdef CIPHER_KEY_LOCK_EN
         key_err      <= 1'b0;
`endif
      end else begin
         // Key port runs independently of the frame FSM.
`ifdef CIPHER_KEY_LOCK_EN
         key_err <= 1'b0;
         if (key_we) begin
            if (state == IDLE) begin
               if (key_ok)
                  key_q[key_idx] <= key_data;
            end else begin
               key_err <= 1'b1;
            end
         end
`else
         if (key_ok)
            key_q[key_idx] <= key_data;
`endif

         case (state)
            IDLE, FILL: begin
               if (accept) begin
                  if (frame_end) begin
                     state        <= DRAIN;
                     frame_len    <= FW'(wr) + FW'(1);
                     rd           <= '0;
                     kidx         <= '0;
                     io.in_ready  <= 1'b0;
                     io.out_valid <= 1'b1;
                  end else begin
                     state <= FILL;
                     wr    <= wr + AW'(1);
                  end
                  busy <= 1'b1;
               end
            end

            DRAIN: begin
               if (drain_end) begin
                  state        <= IDLE;
                  rd           <= '0;
                  wr           <= '0;
                  kidx         <= '0;
                  io.in_ready  <= 1'b1;
                  io.out_valid <= 1'b0;
                  busy         <= 1'b0;
               end else if (drain_fire) begin
                  rd   <= rd + AW'(1);
                  // Wrapping counter rather than rd % SEC_LEN.
                  kidx <= (kidx == KW'(SEC_LEN - 1)) ? '0 : kidx + KW'(1);
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cipher_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cipher_frame_ctrl
// Directed frames plus randomized frames/backpressure/key writes against a
// reference model: plaintext[i] = cipher[i] ^ key[i % SEC_LEN].
// ---------------------------------------------------------------------------
module tb_cipher_frame_ctrl;
   localparam int MSG_LEN = 20;
   localparam int SEC_LEN = 3;

   typedef logic [7:0] bq_t[$];

   logic       clk;
   logic       rst_n;
   logic       key_we;
   logic [1:0] key_idx;
   logic [7:0] key_data;
   logic       busy;
   logic [4:0] frame_len;
`ifdef CIPHER_KEY_LOCK_EN
   logic       key_err;
`endif

   cipher_frame_ctrl_if io();

   cipher_frame_ctrl #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_we   (key_we),
      .key_idx  (key_idx),
      .key_data (key_data),
      .io       (io),
      .busy     (busy),
      .frame_len(frame_len)
`ifdef CIPHER_KEY_LOCK_EN
      ,
      .key_err  (key_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] key_m [SEC_LEN];
   bq_t        got;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_key(input logic [1:0] idx, input logic [7:0] val);
      @(negedge clk);
      key_we = 1'b1; key_idx = idx; key_data = val;
      @(negedge clk);
      key_we = 1'b0;
      if (idx < SEC_LEN) key_m[idx] = val;
   endtask

   task automatic send_frame(input bq_t d, input bit use_last, input bit kw_first,
                             input logic [1:0] kidx, input logic [7:0] kdat);
      for (int i = 0; i < d.size(); i++) begin
         @(negedge clk);
         chk("in_ready_fill", io.in_ready, 1'b1);
         io.in_valid = 1'b1;
         io.in_data  = d[i];
         io.in_last  = use_last && (i == d.size() - 1);
         key_we      = kw_first && (i == 0);
         key_idx     = kidx;
         key_data    = kdat;
      end
      @(negedge clk);
      io.in_valid = 1'b0;
      io.in_last  = 1'b0;
      key_we      = 1'b0;
      if (kw_first && kidx < SEC_LEN) key_m[kidx] = kdat;
      chk("out_valid_first", io.out_valid, 1'b1);
      chk("busy_drain", busy, 1'b1);
   endtask

   // Called at the negedge right after the final ingress byte was accepted.
   task automatic recv_frame(input bq_t d, input bit rnd_bp, input int stall_at,
                             input int kw_at, input logic [7:0] kw_val);
      int         n       = d.size();
      int         i       = 0;
      int         cyc     = 0;
      int         stalls  = 0;
      int         err_ph  = 0;
      bit         held    = 0;
      bit         kw_pend = 0;
      bit         kw_done = 0;
      bit         rdy;
      logic [7:0] hd;
      logic       hl;
      logic [7:0] exp;
      got.delete();
      while (i < n && cyc < 400) begin
         if (kw_pend) begin
            key_we  = 1'b0;
            kw_pend = 0;
            held    = 0;
`ifdef CIPHER_KEY_LOCK_EN
            err_ph = 1;
`else
            key_m[0] = kw_val;
`endif
         end
`ifdef CIPHER_KEY_LOCK_EN
         if (err_ph == 1) begin
            chk("key_err_pulse", key_err, 1'b1);
            err_ph = 2;
         end else if (err_ph == 2) begin
            chk("key_err_clear", key_err, 1'b0);
            err_ph = 3;
         end
`endif
         if (held) begin
            chk("hold_data", io.out_data, hd);
            chk("hold_last", io.out_last, hl);
         end
         chk("in_ready_drain", io.in_ready, 1'b0);
         rdy = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (i == stall_at && stalls < 5) begin
            rdy = 1'b0;
            stalls++;
         end
         if (i == kw_at && !kw_done) begin
            key_we = 1'b1; key_idx = 2'd0; key_data = kw_val;
            kw_pend = 1; kw_done = 1;
         end
         if (io.out_valid && rdy) begin
            exp = d[i] ^ key_m[i % SEC_LEN];
            chk("dout", io.out_data, exp);
            chk("dlast", io.out_last, (i == n - 1));
            got.push_back(io.out_data);
            i++;
            held = 0;
         end else begin
            held = io.out_valid;
            hd   = io.out_data;
            hl   = io.out_last;
         end
         io.out_ready = rdy;
         @(negedge clk);
         cyc++;
      end
      if (kw_pend) begin
         key_we = 1'b0;
`ifndef CIPHER_KEY_LOCK_EN
         key_m[0] = kw_val;
`endif
      end
      io.out_ready = 1'b0;
      if (i < n) chk("drain_timeout", i, n);
      chk("busy_idle", busy, 1'b0);
      chk("in_ready_idle", io.in_ready, 1'b1);
      chk("out_valid_idle", io.out_valid, 1'b0);
      chk("frame_len", frame_len, n);
   endtask

   initial begin
      bq_t d;
      rst_n        = 1'b0;
      key_we       = 1'b0;
      key_idx      = '0;
      key_data     = '0;
      io.in_valid  = 1'b0;
      io.in_data   = '0;
      io.in_last   = 1'b0;
      io.out_ready = 1'b0;
      for (int k = 0; k < SEC_LEN; k++) key_m[k] = '0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", io.in_ready, 1'b1);
      chk("rst_out_valid", io.out_valid, 1'b0);
      chk("rst_out_last", io.out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_len", frame_len, 0);
      rst_n = 1'b1;

      // Key is zero after reset: plaintext equals ciphertext.
      d = '{8'h41};
      send_frame(d, 1, 0, 0, 0);
      recv_frame(d, 0, -1, -1, 0);
      chk("zero_key_byte", got[0], 8'h41);

      write_key(0, 8'h4B); write_key(1, 8'h45); write_key(2, 8'h59);

      // "HEL" with a 5-cycle stall on the second byte.
      d = '{8'h03, 8'h00, 8'h15};
      send_frame(d, 1, 0, 0, 0);
      recv_frame(d, 0, 1, -1, 0);
      chk("hel_0", got[0], 8'h48);
      chk("hel_1", got[1], 8'h45);
      chk("hel_2", got[2], 8'h4C);

      // Full-length frame, no in_last; key index wraps.
      d = {};
      for (int k = 0; k < MSG_LEN; k++) d.push_back(8'h00);
      send_frame(d, 0, 0, 0, 0);
      recv_frame(d, 0, -1, -1, 0);
      chk("full_b19", got[19], 8'h45);

      // Key byte 0 rewritten mid-drain.
      d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(d, 1, 0, 0, 0);
      recv_frame(d, 0, -1, 2, 8'h00);
`ifdef CIPHER_KEY_LOCK_EN
      chk("midkey_b3", got[3], 8'h4B);
`else
      chk("midkey_b3", got[3], 8'h00);
`endif
      write_key(0, 8'h4B);

      // Reset in the middle of FILL.
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         io.in_valid = 1'b1;
         io.in_data  = 8'(k + 1);
      end
      @(negedge clk);
      io.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", io.in_ready, 1'b1);
      chk("abort_out_valid", io.out_valid, 1'b0);
      chk("abort_frame_len", frame_len, 0);
      for (int k = 0; k < SEC_LEN; k++) key_m[k] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      d = '{8'h10, 8'h20};
      send_frame(d, 1, 0, 0, 0);
      recv_frame(d, 0, -1, -1, 0);
      chk("post_rst_0", got[0], 8'h10);
      chk("post_rst_1", got[1], 8'h20);

      // Randomized frames, key updates and backpressure.
      for (int f = 0; f < 40; f++) begin
         int  len;
         bit  ul;
         bit  kwf;
         if ($urandom_range(0, 2) == 0)
            write_key(2'($urandom_range(0, 3)), 8'($urandom));
         len = $urandom_range(1, MSG_LEN);
         ul  = (len < MSG_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
         kwf = ($urandom_range(0, 3) == 0);
         d = {};
         for (int k = 0; k < len; k++) d.push_back(8'($urandom));
         send_frame(d, ul, kwf, 2'($urandom_range(0, 3)), 8'($urandom));
         recv_frame(d, 1, -1, -1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
